// File: rtl/cache_2way_wb.sv
// Two-way set-associative, write-back, write-allocate data cache with a 128-bit line bus.
// Define CACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module cache_2way_wb #(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_en,
    input  logic [3:0]        w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [31:0]       readAddr_addr,
    output logic              readAddr_valid,
    input  logic              readAddr_ready,
    input  logic [127:0]      readData_data,
    input  logic              readData_valid,
    output logic              readData_ready,
    output logic [31:0]       writeAddr_addr,
    output logic              writeAddr_valid,
    input  logic              writeAddr_ready,
    output logic [127:0]      writeData_data,
    output logic [15:0]       writeData_strb,
    output logic              writeData_valid,
    input  logic              writeData_ready,
    input  logic [31:0]       writeResp_msg,
    input  logic              writeResp_valid,
    output logic              writeResp_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int SETS  = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;

    typedef enum logic [2:0] {IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R} state_t;

    state_t state, next_state;

    logic [TAG_W-1:0] tag_mem  [SETS][2];
    logic [127:0]     line_mem [SETS][2];
    logic [1:0]       valid    [SETS];
    logic [1:0]       dirty    [SETS];
    logic [SETS-1:0]  lru;
    logic             victim;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [1:0]         word_sel;
    logic               request;
    logic               is_write;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic               hit_way;
    logic               miss_victim;
    logic               miss_start;
    logic               fill;
    logic [127:0]       hit_line;
    logic [127:0]       merged_line;
    logic               unused_inputs;

    assign idx      = address[INDEX_W+3:4];
    assign addr_tag = address[ADDR_W-1:INDEX_W+4];
    assign word_sel = address[3:2];
    assign request  = r_en | (|w_en);
    assign is_write = |w_en;

    assign hit0     = valid[idx][0] && (tag_mem[idx][0] == addr_tag);
    assign hit1     = valid[idx][1] && (tag_mem[idx][1] == addr_tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = line_mem[idx][hit_way];

    assign read_data = hit ? hit_line[{word_sel, 5'b0} +: 32] : 32'h0;

    assign unused_inputs = ^{writeResp_msg, address[1:0]};

    // Prefer an empty way so a clean fill never displaces live data.
    always_comb begin
        if (!valid[idx][0])
            miss_victim = 1'b0;
        else if (!valid[idx][1])
            miss_victim = 1'b1;
        else
            miss_victim = lru[idx];
    end

    always_comb begin
        merged_line = hit_line;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                if (word_sel == 2'(w) && w_en[b])
                    merged_line[w*32 + b*8 +: 8] = write_data[b*8 +: 8];
    end

    assign readAddr_addr  = 32'({addr_tag, idx, 4'h0});
    assign writeAddr_addr = 32'({tag_mem[idx][victim], idx, 4'h0});
    assign writeData_data = line_mem[idx][victim];
    assign writeData_strb = 16'hffff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state      = state;
        ready           = 1'b0;
        miss_start      = 1'b0;
        fill            = 1'b0;
        readAddr_valid  = 1'b0;
        readData_ready  = 1'b0;
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        writeResp_ready = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        ready = 1'b1;
                    end else begin
                        miss_start = 1'b1;
                        if (valid[idx][miss_victim] && dirty[idx][miss_victim])
                            next_state = WB_AW;
                        else
                            next_state = RD_AR;
                    end
                end
            end
            WB_AW: begin
                writeAddr_valid = 1'b1;
                if (writeAddr_ready)
                    next_state = WB_W;
            end
            WB_W: begin
                writeData_valid = 1'b1;
                if (writeData_ready)
                    next_state = WB_B;
            end
            WB_B: begin
                writeResp_ready = 1'b1;
                if (writeResp_valid)
                    next_state = RD_AR;
            end
            RD_AR: begin
                readAddr_valid = 1'b1;
                if (readAddr_ready)
                    next_state = RD_R;
            end
            RD_R: begin
                readData_ready = 1'b1;
                if (readData_valid) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            victim <= 1'b0;
        else if (miss_start)
            victim <= miss_victim;
    end

    // Valid, dirty and LRU bits are the only array state cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= 2'b00;
                dirty[s] <= 2'b00;
            end
            lru <= '0;
        end else if (ready) begin
            if (is_write)
                dirty[idx][hit_way] <= 1'b1;
            lru[idx] <= ~hit_way;
        end else if (fill) begin
            valid[idx][victim] <= 1'b1;
            dirty[idx][victim] <= 1'b0;
            lru[idx]           <= ~victim;
        end
    end

    always_ff @(posedge clk) begin
        if (ready && is_write) begin
            line_mem[idx][hit_way] <= merged_line;
        end else if (fill) begin
            line_mem[idx][victim] <= readData_data;
            tag_mem[idx][victim]  <= addr_tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // A miss counts once; its post-refill completion is counted as a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (ready)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
